// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: memop codes, state encodings,
// default bus timeout and lane helpers used by the controller.
package lsu_ctrl_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Stores only look at op[1:0]; unknown load codes fall back to signed byte.
    function automatic logic [2:0] norm_memop(input logic is_store, input logic [2:0] op);
        if (is_store) begin
            if (op[1])
                return MEMOP_W;
            else if (op[0])
                return MEMOP_H;
            else
                return MEMOP_B;
        end
        case (op)
            MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU: return op;
            default:                             return MEMOP_B;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
        case (op)
            MEMOP_B, MEMOP_BU: return 4'b0001 << a;
            MEMOP_H, MEMOP_HU: return 4'b0011 << {a[1], 1'b0};
            default:           return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            MEMOP_B, MEMOP_BU: return {4{d[7:0]}};
            MEMOP_H, MEMOP_HU: return {2{d[15:0]}};
            default:           return d;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            MEMOP_H, MEMOP_HU: return a[0];
            MEMOP_W:           return a != 2'b00;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load lane extraction and sign/zero extension; combinational so it can be
// reused by a cache refill path.
module lsu_extend
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  addr,
    input  logic [31:0] bus_rdata,
    output logic [31:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (memop)
            MEMOP_W:  rdata = bus_rdata;
            MEMOP_H:  rdata = {{16{w_half[15]}}, w_half};
            MEMOP_BU: rdata = {24'd0, w_byte};
            MEMOP_HU: rdata = {16'd0, w_half};
            default:  rdata = {{24{w_byte[7]}}, w_byte};
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one req/ack bus transaction per memory command.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
//
// state    | meaning
// LSU_IDLE | waiting for a load/store command
// LSU_REQ  | bus_req held, waiting for bus_ack or timeout
// LSU_DONE | done pulse, rdata valid, error flags pulse
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic        memwr,
    input  logic        memrd,
    input  logic [2:0]  memop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic        r_done;
    logic        r_bus_err;
    logic        r_misalign;
    logic [31:0] r_rdata;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic        w_accept;
    logic [2:0]  w_op;
    logic        w_misalign;
    logic [31:0] w_ext;

    assign w_accept = (r_state == LSU_IDLE) && cmd_valid && (memwr || memrd);
    assign w_op     = norm_memop(memwr, memop);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(w_op, addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    lsu_extend u_extend (
        .memop     (r_op),
        .addr      (r_addr_lo),
        .bus_rdata (bus_rdata),
        .rdata     (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LSU_IDLE;
            r_cnt       <= 16'd0;
            r_op        <= MEMOP_B;
            r_addr_lo   <= 2'd0;
            r_done      <= 1'b0;
            r_bus_err   <= 1'b0;
            r_misalign  <= 1'b0;
            r_rdata     <= 32'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            r_done     <= 1'b0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_op        <= w_op;
                        r_addr_lo   <= addr[1:0];
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_be    <= byte_en(w_op, addr[1:0]);
                        r_bus_wdata <= lane_wdata(w_op, wdata);
                        r_cnt       <= 16'd0;
                        if (w_misalign) begin
                            r_state    <= LSU_DONE;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                            r_rdata    <= 32'd0;
                        end else begin
                            r_state   <= LSU_REQ;
                            r_bus_req <= 1'b1;
                            r_bus_we  <= memwr;
                        end
                    end
                end
                LSU_REQ: begin
                    // An ack in the final counted cycle still wins over the timeout.
                    if (bus_ack) begin
                        r_state   <= LSU_DONE;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_done    <= 1'b1;
                        if (!r_bus_we)
                            r_rdata <= w_ext;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state   <= LSU_DONE;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_bus_err <= 1'b1;
                        r_rdata   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                LSU_DONE: r_state <= LSU_IDLE;
                default:  r_state <= LSU_IDLE;
            endcase
        end
    end

    // Reset forces stall low even while the core keeps cmd_valid asserted.
    assign stall     = rst_n && (w_accept || (r_state == LSU_REQ));
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;
    assign misalign  = r_misalign;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed cases plus randomized commands
// checked against a behavioural model of the load/store rules.
module tb_lsu_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        memwr = 1'b0;
    logic        memrd = 1'b0;
    logic [2:0]  memop = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, done, bus_err, misalign, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .memwr(memwr),
        .memrd(memrd), .memop(memop), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .bus_err(bus_err),
        .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; bit err; bit mis; } exp_t;
    typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int cycles; } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int total = 0;
    int bad = 0;
    int ack_dly = 0;
    logic [31:0] model_held = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference rules: size/signedness from memop, lanes from address arithmetic.
    task automatic model(input bit we, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly,
                         output exp_t e, output bus_t b, output bit has_bus, output int lat);
        int size;
        bit uns;
        bit mis;
        int shift;
        logic [31:0] mask, v;
        uns = 0;
        if (we) size = op[1] ? 4 : (op[0] ? 2 : 1);
        else begin
            case (op)
                3'd1: size = 2;
                3'd2: size = 4;
                3'd4: begin size = 1; uns = 1; end
                3'd5: begin size = 2; uns = 1; end
                default: size = 1;
            endcase
        end
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
`else
        mis = 0;
`endif
        b.we = we;
        b.addr = a & 32'hFFFF_FFFC;
        if (size == 1) begin
            b.be = 4'(1 << a[1:0]);
            b.wdata = (wd & 32'hFF) * 32'h0101_0101;
            shift = 8 * int'(a[1:0]);
            mask = 32'hFF;
        end else if (size == 2) begin
            b.be = 4'(3 << (2 * int'(a[1])));
            b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            shift = 16 * int'(a[1]);
            mask = 32'hFFFF;
        end else begin
            b.be = 4'hF;
            b.wdata = wd;
            shift = 0;
            mask = 32'hFFFF_FFFF;
        end
        b.cycles = (dly < T) ? dly + 1 : T;
        e.err = 0;
        e.mis = 0;
        if (mis) begin
            has_bus = 0; e.mis = 1; model_held = 0; lat = 2;
        end else if (dly >= T) begin
            has_bus = 1; e.err = 1; model_held = 0; lat = 2 + T;
        end else begin
            has_bus = 1; lat = 3 + dly;
            if (!we) begin
                v = (rd >> shift) & mask;
                if (!uns && size < 4 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
                model_held = v;
            end
        end
        e.rdata = model_held;
    endtask

    task automatic issue(input bit we, input bit rd, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, input int dly, input string tag);
        exp_t e;
        bus_t b;
        bit hb;
        int lat;
        int cyc;
        bit timed_out;
        if (we || rd) begin
            model(we, op, a, wd, rdat, dly, e, b, hb, lat);
            if (hb) bus_q.push_back(b);
            exp_q.push_back(e);
        end
        ack_dly = dly;
        bus_rdata = rdat;
        @(negedge clk);
        cmd_valid = 1; memwr = we; memrd = rd; memop = op; addr = a; wdata = wd;
        #1;
        chk({tag, " stall_accept"}, 32'(stall), 32'(we || rd));
        if (!(we || rd)) begin
            @(negedge clk);
            chk({tag, " nocmd_bus_req"}, 32'(bus_req), 0);
            chk({tag, " nocmd_stall"}, 32'(stall), 0);
            cmd_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        memwr = 1'($urandom); memrd = 1'($urandom); memop = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        cyc = 1;
        timed_out = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) break;
            chk({tag, " stall_busy"}, 32'(stall), 1);
            if (cyc > 300) begin
                timed_out = 1;
                total++; bad++;
                $display("FAIL %s done_wait: got no done expected done within 300 cycles", tag);
                break;
            end
        end
        if (!timed_out) begin
            chk({tag, " latency"}, 32'(cyc), 32'(lat));
            chk({tag, " stall_done"}, 32'(stall), 0);
        end
        cmd_valid = 0; memwr = 0; memrd = 0;
    endtask

    // Bus responder: ack after ack_dly wait cycles, random noise while idle.
    initial begin
        int rc = 0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                bus_ack = (rc == ack_dly);
                rc++;
            end else begin
                rc = 0;
                bus_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Done monitor: result checks and rdata hold between completions.
    initial begin
        exp_t e;
        logic [31:0] held = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin held = 0; continue; end
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_rdata", rdata, e.rdata);
                    chk("done_bus_err", 32'(bus_err), 32'(e.err));
                    chk("done_misalign", 32'(misalign), 32'(e.mis));
                    held = e.rdata;
                end
            end else begin
                chk("rdata_hold", rdata, held);
                chk("idle_bus_err", 32'(bus_err), 0);
                chk("idle_misalign", 32'(misalign), 0);
            end
        end
    end

    // Bus monitor: fields per REQ cycle and number of REQ cycles.
    initial begin
        bus_t cur;
        bit prev = 0;
        bit have = 0;
        int n = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev = 0; have = 0; continue; end
            if (bus_req) begin
                if (!prev) begin
                    n = 0;
                    if (bus_q.size() == 0) begin
                        have = 0;
                        total++; bad++;
                        $display("FAIL bus_unexpected: got bus_req=1 expected no access");
                    end else begin
                        cur = bus_q.pop_front();
                        have = 1;
                    end
                end
                if (have) begin
                    chk("bus_we", 32'(bus_we), 32'(cur.we));
                    chk("bus_addr", bus_addr, cur.addr);
                    chk("bus_be", 32'(bus_be), 32'(cur.be));
                    if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
                end
                n++;
            end else if (prev && have) begin
                chk("req_cycles", 32'(n), 32'(cur.cycles));
                have = 0;
            end
            prev = bus_req;
        end
    end

    initial begin
        #1;
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_be", 32'(bus_be), 0);
        chk("rst_addr", bus_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        issue(1, 0, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h0, 0, "sw");
        issue(1, 0, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, "sb");
        issue(0, 1, 3'b000, 32'h4002, 32'h0, 32'h80FF7F01, 0, "lb");
        chk("lb_value", rdata, 32'hFFFFFFFF);
        issue(0, 1, 3'b100, 32'h4003, 32'h0, 32'h80FF7F01, 1, "lbu");
        chk("lbu_value", rdata, 32'h00000080);
        issue(0, 1, 3'b001, 32'h4000, 32'h0, 32'h80FF7F01, 0, "lh");
        chk("lh_value", rdata, 32'h00007F01);
        issue(0, 1, 3'b101, 32'h4002, 32'h0, 32'h80FF7F01, 2, "lhu");
        chk("lhu_value", rdata, 32'h000080FF);
        issue(1, 0, 3'b001, 32'h5002, 32'h1234ABCD, 32'h0, 5, "sh_wait5");
        issue(0, 1, 3'b010, 32'h6000, 32'h0, 32'h11223344, 100, "lw_timeout");
        chk("timeout_rdata", rdata, 32'h0);
        issue(0, 1, 3'b010, 32'h6004, 32'h0, 32'hCAFEF00D, T - 1, "lw_last_ack");
        issue(0, 1, 3'b010, 32'h1002, 32'h0, 32'h89ABCDEF, 0, "lw_misaligned");
        issue(0, 0, 3'b010, 32'h7000, 32'h0, 32'h0, 0, "nocmd");

        // Reset in the middle of a stalled load.
        begin
            bus_t b;
            b.we = 0; b.addr = 32'h3000; b.be = 4'hF; b.wdata = 0; b.cycles = 0;
            bus_q.push_back(b);
            ack_dly = 1000;
            @(negedge clk);
            cmd_valid = 1; memrd = 1; memop = 3'b010; addr = 32'h3000;
            @(posedge clk);
            repeat (3) @(negedge clk);
            #2 rst_n = 0;
            #1;
            chk("midrst_bus_req", 32'(bus_req), 0);
            chk("midrst_stall", 32'(stall), 0);
            chk("midrst_done", 32'(done), 0);
            bus_q.delete();
            exp_q.delete();
            cmd_valid = 0; memrd = 0;
            model_held = 0;
            repeat (2) @(negedge clk);
            rst_n = 1;
        end
        issue(0, 1, 3'b010, 32'h2000, 32'h0, 32'h5A5A1234, 0, "lw_after_rst");

        for (int i = 0; i < 40; i++) begin
            int k;
            int d;
            k = $urandom_range(0, 7);
            d = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            issue(k < 3 || k == 6, k >= 3 && k != 7 || k == 6, 3'($urandom), $urandom,
                  $urandom, $urandom, d, "rand");
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit that executes the memory commands produced by the instruction decoder (memwr, MemtoReg, memop).
- Converts each command into a single request/acknowledge transaction on the data bus, generates byte enables and write-lane replication, and sign- or zero-extends load data.
- Stalls the core until the transaction completes.
- Sits between the execute stage (ALU result as address, rs2 as store data) and the data memory/peripheral bus.

Parameters:
- TIMEOUT_CYCLES, 255: number of cycles bus_req may stay high without bus_ack before the access is aborted with bus_err (range 1..65535).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  execute stage presents a command this cycle
- memwr  in  1  store command
- memrd  in  1  load command (decoder MemtoReg); memwr has priority if both are set
- memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; any other load code is treated as 000; store codes use bits[1:0] (11 treated as word)
- addr  in  32  byte address
- wdata  in  32  store data (rs2)
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse when the command retires
- rdata  out  32  extended load result, valid while done=1
- bus_err  out  1  one-cycle pulse with done on timeout
- misalign  out  1  one-cycle pulse with done on misaligned access (only when LSU_MISALIGN_TRAP_EN is defined; tied 0 otherwise)
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write strobe
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus accepts write, or read data valid
- bus_rdata  in  32  read data word

Behaviour:
- States: IDLE, REQ, DONE.
- Reset (asynchronous, mid-operation included): state=IDLE; all outputs 0, including bus_req (immediately); timeout counter = 0; any in-flight access is dropped.
- IDLE: a command is accepted when cmd_valid & (memwr|memrd). On acceptance, latch we, memop, addr, wdata and go to REQ. stall is combinationally 1 in the accepting cycle. If cmd_valid=1 with neither memwr nor memrd, nothing happens and stall=0.
- REQ:
  - bus_req=1; bus_we/addr/be/wdata are driven from the latched values and are stable until ack.
  - The counter increments each cycle.
  - bus_ack=1 (including the first REQ cycle): capture the extended bus_rdata for loads and go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: drop bus_req, set rdata=0, flag error, go to DONE.
- DONE: done=1, stall=0, rdata valid, bus_err pulses if flagged. Next state is IDLE. A new command is sampled only from IDLE.
- Total latency with zero-wait ack: accept cycle, then REQ, then DONE, i.e. 3 cycles from cmd_valid to done.
- bus_ack outside REQ is ignored. cmd_valid outside IDLE is ignored; the core holds it because stall is high.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data: bus_wdata replicates the byte ({4{wdata[7:0]}}), the half ({2{wdata[15:0]}}), or passes the word through.
- Load extraction: select the lane by addr[1:0] (byte) or addr[1] (half); sign-extend for b/h, zero-extend for bu/hu; word passes through.
- rdata holds its value after done until the next load completes.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus access. IDLE goes to DONE directly, with misalign=1, done=1, rdata=0 (2-cycle latency).
- Undefined: the low address bits are ignored for alignment purposes (half uses addr[1], word uses the aligned word) and the access proceeds normally. misalign is constant 0.

Decomposition:
- define.v gains:
  - the MEMOP codes (MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU)
  - the LSU state encodings (LSU_IDLE, LSU_REQ, LSU_DONE)
  - the default timeout value
- One combinational sub-module, lsu_extend (inputs: memop, addr[1:0], bus_rdata; output: rdata), is shared with any future cache refill path. lsu_ctrl instantiates it once.

Test Plan:
- Store word: memwr, memop=010, addr=0x1000, wdata=0xDEADBEEF, ack on the first REQ cycle -> bus_addr=0x1000, be=1111, wdata=0xDEADBEEF, done at cycle 3, stall high for cycles 1-2.
- Store byte: addr=0x1003, wdata=0x000000A5 -> be=1000, bus_wdata=0xA5A5A5A5, bus_we=1.
- Loads from bus_rdata=0x80FF7F01:
  - lb at addr 0x..2 -> rdata=0xFFFFFFFF
  - lbu at addr 0x..3 -> rdata=0x00000080
  - lh at addr 0x..0 -> rdata=0x00007F01
  - lhu at addr 0x..2 -> rdata=0x000080FF
- Wait states and timeout:
  - ack delayed 5 cycles -> bus_req and fields stable for all 6 REQ cycles, single done.
  - TIMEOUT_CYCLES=8 with no ack -> bus_req drops after 8 cycles, done=1 with bus_err=1 and rdata=0.
- Reset mid-access: rst_n low during REQ -> bus_req=0 and stall=0 immediately. After release, a fresh lw to 0x2000 completes normally.
- Misaligned lw at addr=0x1002:
  - with LSU_MISALIGN_TRAP_EN -> no bus_req, done and misalign pulse at cycle 2.
  - without it -> bus_addr=0x1000, be=1111, normal completion.
